ysyx_lsu_mem_responder: RTL and testbench

Memory-side responder for the LSU load/store bus: accepts one read (ar*) or write (aw*/w*) request at a time and serves it from an internal word-addressed SRAM after a programmable latency. Returns the full aligned word on reads; the LSU performs its own lane shift and sign extension. Aligns byte/half writes onto the correct lanes. Used as the data-memory model behind the LSU in simulation, and as a scratchpad in synthesis.

---
 rtl/ysyx_lsu_bus_pkg.sv | 29 ++
 rtl/ysyx_lsu_sram_bank.sv | 26 ++
 rtl/ysyx_lsu_mem_responder.sv | 116 +++++++++++
 tb/tb_ysyx_lsu_mem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_lsu_bus_pkg.sv
// Shared types, strobe encodings and alignment/fault helpers for the LSU memory bus.
package ysyx_lsu_bus_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} lsu_state_e;

   localparam logic [7:0] STRB_B = 8'h1;
   localparam logic [7:0] STRB_H = 8'h3;
   localparam logic [7:0] STRB_W = 8'hf;

   // Legal accesses never spill past lane 3, so the truncated shift is exact.
   function automatic logic [3:0] align_wstrb(input logic [7:0] strb, input logic [1:0] lo);
      logic [3:0] size_lanes;
      size_lanes = strb[3:0];
      return size_lanes << lo;
   endfunction

   // Size/alignment fault only; the address window is checked by the caller.
   function automatic logic access_fault(input logic [7:0] strb, input logic [1:0] lo);
      logic fault;
      case (strb)
         STRB_B:  fault = 1'b0;
         STRB_H:  fault = (lo == 2'd3);
         STRB_W:  fault = (lo != 2'd0);
         default: fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/ysyx_lsu_sram_bank.sv
// Word-addressed SRAM with per-byte write enables and a combinational read port.
module ysyx_lsu_sram_bank #(
   parameter int MEM_WORDS = 1024
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(MEM_WORDS)-1:0] idx,
   input  logic [3:0]                   wbe,
   input  logic [31:0]                  wdata,
   output logic [31:0]                  rdata
);

   logic [31:0] mem [MEM_WORDS];

   // Contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_lsu_mem_responder.sv
// LSU data-memory responder: serves one read or write at a time from an internal
// SRAM after LAT cycles, then spends one turnaround cycle ignoring the valids.
module ysyx_lsu_mem_responder
   import ysyx_lsu_bus_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                MEM_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int                LAT       = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic              lsu_arvalid,
   input  logic [7:0]        lsu_rstrb,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_rvalid,
   input  logic [ADDR_W-1:0] lsu_awaddr,
   input  logic              lsu_awvalid,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wstrb,
   input  logic              lsu_wvalid,
   output logic              lsu_wready,
   output logic              lsu_err
);

   localparam int                IDX_W     = $clog2(MEM_WORDS);
   localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * MEM_WORDS);
   localparam logic [3:0]        CNT_INIT  = 4'(LAT - 1);

   lsu_state_e        state;
   logic [3:0]        cnt;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [7:0]        req_strb;
   logic [DATA_W-1:0] rdata_q;

   logic [ADDR_W-1:0] offset;
   logic [1:0]        lo;
   logic              in_range;
   logic              fault;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] lane_data;
   logic [3:0]        lane_strb;
   logic              sram_we;
   logic [DATA_W-1:0] sram_rdata;

   assign offset    = req_addr - BASE_ADDR;
   assign lo        = req_addr[1:0];
   assign in_range  = (req_addr >= BASE_ADDR) && (offset < MEM_BYTES);
   assign fault     = !in_range || access_fault(req_strb, lo);
   assign idx       = offset[IDX_W+1:2];
   assign lane_data = req_wdata << {lo, 3'b000};
   assign lane_strb = align_wstrb(req_strb, lo);
   // A reset landing on the response cycle must not let the write through.
   assign sram_we   = (state == RESP) && req_write && !fault && !rst;

   ysyx_lsu_sram_bank #(
      .MEM_WORDS(MEM_WORDS)
   ) u_bank (
      .clk  (clk),
      .we   (sram_we),
      .idx  (idx),
      .wbe  (lane_strb),
      .wdata(lane_data),
      .rdata(sram_rdata)
   );

   assign lsu_rvalid = (state == RESP) && !req_write;
   assign lsu_wready = (state == RESP) && req_write;
   assign lsu_err    = (state == RESP) && fault;
   assign lsu_rdata  = lsu_rvalid ? (fault ? '0 : sram_rdata) : rdata_q;

   // Writes take priority at accept; a concurrent read stays pending on the bus.
   // The counter holds the remaining WAIT cycles so RESP lands exactly LAT cycles
   // after the accept cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (lsu_awvalid && lsu_wvalid) begin
                  req_write <= 1'b1;
                  req_addr  <= lsu_awaddr;
                  req_wdata <= lsu_wdata;
                  req_strb  <= lsu_wstrb;
                  cnt       <= CNT_INIT;
                  state     <= (LAT == 1) ? RESP : WAIT;
               end else if (lsu_arvalid) begin
                  req_write <= 1'b0;
                  req_addr  <= lsu_araddr;
                  req_strb  <= lsu_rstrb;
                  cnt       <= CNT_INIT;
                  state     <= (LAT == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP: begin
               if (!req_write) rdata_q <= lsu_rdata;
               state <= TURN;
            end
            TURN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_lsu_mem_responder.sv
// Randomized bench for ysyx_lsu_mem_responder at LAT = 2, 1 and 15, checked
// against a byte-level memory model built from the access rules.
module tb_ysyx_lsu_mem_responder;

   localparam int          NDUT  = 3;
   localparam int          LATS [NDUT] = '{2, 1, 15};
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          WORDS = 1024;

   logic        clk = 1'b0;
   logic        rst     [NDUT];
   logic [31:0] araddr  [NDUT];
   logic        arvalid [NDUT];
   logic [7:0]  rstrb   [NDUT];
   logic [31:0] rdata   [NDUT];
   logic        rvalid  [NDUT];
   logic [31:0] awaddr  [NDUT];
   logic        awvalid [NDUT];
   logic [31:0] wdata   [NDUT];
   logic [7:0]  wstrb   [NDUT];
   logic        wvalid  [NDUT];
   logic        wready  [NDUT];
   logic        err     [NDUT];

   logic [31:0] model_mem  [NDUT][WORDS];
   logic [31:0] last_rdata [NDUT];
   int          check_count = 0;
   int          pass_count  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ysyx_lsu_mem_responder #(
         .LAT(LATS[g])
      ) u_dut (
         .clk        (clk),
         .rst        (rst[g]),
         .lsu_araddr (araddr[g]),
         .lsu_arvalid(arvalid[g]),
         .lsu_rstrb  (rstrb[g]),
         .lsu_rdata  (rdata[g]),
         .lsu_rvalid (rvalid[g]),
         .lsu_awaddr (awaddr[g]),
         .lsu_awvalid(awvalid[g]),
         .lsu_wdata  (wdata[g]),
         .lsu_wstrb  (wstrb[g]),
         .lsu_wvalid (wvalid[g]),
         .lsu_wready (wready[g]),
         .lsu_err    (err[g])
      );
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected) pass_count++;
      else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
   endtask

   // An access faults when it leaves the window, has an unknown size, or crosses a word.
   function automatic bit model_fault(input logic [31:0] addr, input logic [7:0] strb);
      longint a;
      int     size;
      a = longint'(addr);
      if (a < longint'(BASE) || a >= longint'(BASE) + 4 * WORDS) return 1'b1;
      case (strb)
         8'h01:   size = 1;
         8'h03:   size = 2;
         8'h0f:   size = 4;
         default: return 1'b1;
      endcase
      return (int'(addr[1:0]) + size) > 4;
   endfunction

   function automatic int model_size(input logic [7:0] strb);
      return (strb == 8'h01) ? 1 : (strb == 8'h03) ? 2 : 4;
   endfunction

   function automatic int model_idx(input logic [31:0] addr);
      return int'((addr - BASE) >> 2) % WORDS;
   endfunction

   // One full transaction, starting and ending mid-cycle with the DUT idle.
   // Valids are held through the turnaround cycle, which must not re-serve them.
   task automatic applyStimulus(input int d, input bit is_write, input logic [31:0] addr,
                                input logic [31:0] data, input logic [7:0] strb);
      bit          fault;
      bit          seen;
      int          k;
      int          idx;
      int          lo;
      logic [31:0] exp_rdata;
      fault = model_fault(addr, strb);
      idx   = model_idx(addr);
      lo    = int'(addr[1:0]);
      if (is_write) begin
         awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
         awvalid[d] = 1'b1; wvalid[d] = 1'b1;
      end else begin
         araddr[d] = addr; rstrb[d] = strb; arvalid[d] = 1'b1;
      end
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (rvalid[d] || wready[d]) seen = 1'b1;
      end
      checkOutput($sformatf("latency d%0d", d), 32'(k), 32'(LATS[d]));
      checkOutput($sformatf("pulse kind d%0d", d), 32'({rvalid[d], wready[d]}), is_write ? 32'd1 : 32'd2);
      checkOutput($sformatf("err d%0d @%h", d, addr), 32'(err[d]), 32'(fault));
      if (!is_write) begin
         exp_rdata = fault ? 32'd0 : model_mem[d][idx];
         checkOutput($sformatf("rdata d%0d @%h", d, addr), rdata[d], exp_rdata);
         last_rdata[d] = exp_rdata;
      end else if (!fault) begin
         for (int i = 0; i < model_size(strb); i++)
            model_mem[d][idx][8*(lo+i) +: 8] = data[8*i +: 8];
      end
      @(negedge clk);
      checkOutput($sformatf("turn quiet d%0d", d), 32'({rvalid[d], wready[d], err[d]}), 32'd0);
      checkOutput($sformatf("rdata hold d%0d", d), rdata[d], last_rdata[d]);
      awvalid[d] = 1'b0; wvalid[d] = 1'b0; arvalid[d] = 1'b0;
      @(negedge clk);
   endtask

   task automatic simultaneousAccess(input int d, input logic [31:0] addr, input logic [31:0] data);
      int          k;
      int          kw;
      int          kr;
      logic [31:0] got;
      awaddr[d] = addr; wdata[d] = data; wstrb[d] = 8'h0f;
      araddr[d] = addr; rstrb[d] = 8'h0f;
      awvalid[d] = 1'b1; wvalid[d] = 1'b1; arvalid[d] = 1'b1;
      k = 0; kw = -1; kr = -1; got = 32'd0;
      while (kr < 0 && k < 80) begin
         @(negedge clk);
         k++;
         if (wready[d]) begin
            kw = k; awvalid[d] = 1'b0; wvalid[d] = 1'b0;
         end
         if (rvalid[d]) begin
            kr = k; got = rdata[d]; arvalid[d] = 1'b0;
         end
      end
      awvalid[d] = 1'b0; wvalid[d] = 1'b0; arvalid[d] = 1'b0;
      model_mem[d][model_idx(addr)] = data;
      last_rdata[d] = data;
      checkOutput($sformatf("both: write latency d%0d", d), 32'(kw), 32'(LATS[d]));
      checkOutput($sformatf("both: read latency d%0d", d), 32'(kr), 32'(2 * LATS[d] + 2));
      checkOutput($sformatf("both: read data d%0d", d), got, data);
      @(negedge clk);
      @(negedge clk);
   endtask

   // Reset lands the cycle after a store is accepted; the store must vanish.
   task automatic resetMidWrite(input int d, input logic [31:0] addr);
      int pulses;
      awaddr[d] = addr; wdata[d] = ~model_mem[d][model_idx(addr)]; wstrb[d] = 8'h0f;
      awvalid[d] = 1'b1; wvalid[d] = 1'b1;
      @(negedge clk);
      rst[d] = 1'b1; awvalid[d] = 1'b0; wvalid[d] = 1'b0;
      @(negedge clk);
      rst[d] = 1'b0;
      pulses = 0;
      for (int i = 0; i < LATS[d] + 3; i++) begin
         if (rvalid[d] || wready[d] || err[d]) pulses++;
         @(negedge clk);
      end
      checkOutput($sformatf("reset abandons d%0d", d), 32'(pulses), 32'd0);
      checkOutput($sformatf("reset rdata d%0d", d), rdata[d], 32'd0);
      last_rdata[d] = 32'd0;
      applyStimulus(d, 1'b0, addr, 32'd0, 8'h0f);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0]  strb_tab [8];
      logic [31:0] addr;
      logic [7:0]  strb;
      strb_tab = '{8'h01, 8'h03, 8'h0f, 8'h01, 8'h03, 8'h0f, 8'h07, 8'h13};
      for (int d = 0; d < NDUT; d++) begin
         rst[d] = 1'b1; arvalid[d] = 1'b0; awvalid[d] = 1'b0; wvalid[d] = 1'b0;
         araddr[d] = '0; awaddr[d] = '0; wdata[d] = '0; rstrb[d] = '0; wstrb[d] = '0;
         last_rdata[d] = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < NDUT; d++)
         checkOutput($sformatf("reset outputs d%0d", d),
                     32'({rvalid[d], wready[d], err[d]}) | rdata[d], 32'd0);

      for (int d = 0; d < NDUT; d++) begin
         $display("[TB] instance %0d, LAT=%0d", d, LATS[d]);
         for (int w = 0; w < 16; w++)
            applyStimulus(d, 1'b1, BASE + 32'(4 * w), $urandom, 8'h0f);
         applyStimulus(d, 1'b1, BASE + 32'h0ffc, $urandom, 8'h0f);

         applyStimulus(d, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0f);
         applyStimulus(d, 1'b0, 32'h8000_0010, 32'd0, 8'h0f);
         applyStimulus(d, 1'b1, 32'h8000_0013, 32'h0000_00AA, 8'h01);
         applyStimulus(d, 1'b1, 32'h8000_0010, 32'h0000_1234, 8'h03);
         applyStimulus(d, 1'b0, 32'h8000_0010, 32'd0, 8'h0f);
         checkOutput($sformatf("merged word d%0d", d), last_rdata[d], 32'hAAAD_1234);
         applyStimulus(d, 1'b1, 32'h8000_0002, 32'h5555_5555, 8'h0f);
         applyStimulus(d, 1'b0, 32'h8000_0000, 32'd0, 8'h0f);
         applyStimulus(d, 1'b0, 32'h7FFF_FFFC, 32'd0, 8'h0f);

         simultaneousAccess(d, 32'h8000_0020, $urandom);
         if (LATS[d] > 1) resetMidWrite(d, 32'h8000_0014);

         for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 7))
               0:       addr = 32'h7FFF_FFFC;
               1:       addr = BASE + 32'h1000 + $urandom_range(0, 3);
               2:       addr = BASE + 32'h0ffc + $urandom_range(0, 3);
               default: addr = BASE + $urandom_range(0, 63);
            endcase
            strb = strb_tab[$urandom_range(0, 7)];
            applyStimulus(d, 1'($urandom_range(0, 1)), addr, $urandom, strb);
         end
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
